// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped, one-word-per-line, read-only instruction cache
//            with same-cycle hits, a two-state refill FSM and a miss counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
  parameter int SETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [SETS-1:0]      r_valid;
  logic [TAG_W-1:0]     r_tag  [SETS];
  logic [31:0]          r_data [SETS];
  logic [31:2]          r_maddr;
  logic [31:0]          r_miss_count;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [IDX_W-1:0]     w_fidx;
  logic [TAG_W-1:0]     w_ftag;
  logic                 w_match;
  logic                 w_start;
  logic                 w_fill;
  logic                 w_unused;

  assign w_idx    = imemaddr[IDX_W+1:2];
  assign w_tag    = imemaddr[31:IDX_W+2];
  assign w_fidx   = r_maddr[IDX_W+1:2];
  assign w_ftag   = r_maddr[31:IDX_W+2];
  assign w_match  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_unused = &{1'b0, imemaddr[1:0]};

  assign imemload   = r_data[w_idx];
  assign miss_count = r_miss_count;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_valid      <= '0;
      r_maddr      <= '0;
      r_miss_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        r_maddr      <= imemaddr[31:2];
        r_miss_count <= r_miss_count + 32'd1;
      end
      if (w_fill) begin
        r_valid[w_fidx] <= 1'b1;
      end
    end
  end

  // Line payload carries no reset; the valid bit alone qualifies it.
  always_ff @(posedge CLK) begin
    if (nRST && w_fill) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= iload;
    end
  end

  always_comb begin
    w_next_state = r_state;
    ihit         = 1'b0;
    iREN         = 1'b0;
    iaddr        = 32'd0;
    w_start      = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      IDLE: begin
        ihit = nRST && imemREN && w_match;
        if (imemREN && !w_match) begin
          w_start      = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        // Refill always finishes to the latched address; no abort path.
        iREN  = nRST;
        iaddr = {r_maddr, 2'b00};
        if (!iwait) begin
          w_fill       = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module   : tb_icache
// Purpose  : Directed self-checking bench for the icache block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic [31:0] miss_count;

  int n_checks;
  int n_errors;

  icache #(.SETS(16)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .imemREN   (imemREN),
    .imemaddr  (imemaddr),
    .ihit      (ihit),
    .imemload  (imemload),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .miss_count(miss_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Caller has imemaddr set to a missing address in IDLE (cycle 0).
  // Holds iwait high for 'waits' FETCH cycles, then returns data.
  task automatic refill(input logic [31:0] addr, input logic [31:0] data, input int waits);
    check("miss_ihit", {31'd0, ihit}, 32'd0);
    check("miss_iren_idle", {31'd0, iREN}, 32'd0);
    step();
    for (int w = 0; w < waits; w++) begin
      iwait = 1'b1;
      #1;
      check("fetch_iren", {31'd0, iREN}, 32'd1);
      check("fetch_iaddr", iaddr, {addr[31:2], 2'b00});
      check("fetch_ihit", {31'd0, ihit}, 32'd0);
      step();
    end
    iwait = 1'b0;
    iload = data;
    #1;
    check("fetch_last_iren", {31'd0, iREN}, 32'd1);
    check("fetch_last_iaddr", iaddr, {addr[31:2], 2'b00});
    step();
    iwait = 1'b1;
    iload = 32'hDEAD_BEEF;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nRST     = 1'b0;
    imemREN  = 1'b1;
    imemaddr = 32'h0;
    iwait    = 1'b1;
    iload    = 32'h0;

    // Reset state
    step();
    step();
    check("rst_ihit", {31'd0, ihit}, 32'd0);
    check("rst_iren", {31'd0, iREN}, 32'd0);
    check("rst_miss_count", miss_count, 32'd0);

    // Cold miss on 0x0, two wait cycles then data
    nRST = 1'b1;
    #1;
    refill(32'h0, 32'h2001_0005, 2);
    check("t1_ihit", {31'd0, ihit}, 32'd1);
    check("t1_load", imemload, 32'h2001_0005);
    check("t1_iren", {31'd0, iREN}, 32'd0);
    check("t1_iaddr", iaddr, 32'd0);
    check("t1_mc", miss_count, 32'd1);

    // Rereads hit every cycle
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_ihit", {31'd0, ihit}, 32'd1);
      check("t2_iren", {31'd0, iREN}, 32'd0);
      check("t2_mc", miss_count, 32'd1);
    end
    imemREN = 1'b0;
    #1;
    check("t2_noren_ihit", {31'd0, ihit}, 32'd0);
    imemREN = 1'b1;

    // Conflict on idx 0: 0x40 evicts 0x0, then 0x0 misses again
    imemaddr = 32'h40;
    #1;
    refill(32'h40, 32'h0000_0040, 0);
    check("t3_ihit40", {31'd0, ihit}, 32'd1);
    check("t3_load40", imemload, 32'h0000_0040);
    check("t3_mc2", miss_count, 32'd2);
    imemaddr = 32'h0;
    #1;
    refill(32'h0, 32'h2001_0005, 1);
    check("t3_ihit0", {31'd0, ihit}, 32'd1);
    check("t3_load0", imemload, 32'h2001_0005);
    check("t3_mc3", miss_count, 32'd3);

    // Address change mid-FETCH: refill still completes to 0x8
    imemaddr = 32'h8;
    #1;
    check("t4_miss8", {31'd0, ihit}, 32'd0);
    step();
    imemaddr = 32'h100;
    iwait    = 1'b1;
    #1;
    check("t4_iaddr_hold", iaddr, 32'h8);
    check("t4_iren_hold", {31'd0, iREN}, 32'd1);
    step();
    iwait = 1'b0;
    iload = 32'h0000_0008;
    #1;
    check("t4_iaddr_last", iaddr, 32'h8);
    step();
    iwait = 1'b1;
    #1;
    check("t4_miss100", {31'd0, ihit}, 32'd0);
    check("t4_mc4", miss_count, 32'd4);
    step();
    check("t4_iaddr100", iaddr, 32'h100);
    check("t4_mc5", miss_count, 32'd5);
    iwait = 1'b0;
    iload = 32'h0000_0100;
    step();
    iwait = 1'b1;
    #1;
    check("t4_hit100", {31'd0, ihit}, 32'd1);
    check("t4_load100", imemload, 32'h0000_0100);
    imemaddr = 32'h8;
    #1;
    check("t4_hit8", {31'd0, ihit}, 32'd1);
    check("t4_load8", imemload, 32'h0000_0008);

    // Reset during FETCH abandons the refill
    imemaddr = 32'h14;
    #1;
    check("t5_miss14", {31'd0, ihit}, 32'd0);
    step();
    check("t5_fetch_iren", {31'd0, iREN}, 32'd1);
    nRST = 1'b0;
    #1;
    check("t5_rst_iren_comb", {31'd0, iREN}, 32'd0);
    step();
    check("t5_rst_iren", {31'd0, iREN}, 32'd0);
    check("t5_rst_mc", miss_count, 32'd0);
    nRST     = 1'b1;
    imemaddr = 32'h8;
    #1;
    check("t5_post_miss8", {31'd0, ihit}, 32'd0);
    step();
    check("t5_post_iaddr", iaddr, 32'h8);
    check("t5_post_mc", miss_count, 32'd1);
    iwait = 1'b0;
    iload = 32'h0000_0888;
    step();
    iwait = 1'b1;
    #1;
    check("t5_post_hit", {31'd0, ihit}, 32'd1);
    check("t5_post_load", imemload, 32'h0000_0888);

    // Sequential sweep of all 16 lines, then a second all-hit pass
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    for (int i = 0; i < 16; i++) begin
      imemaddr = 32'(i * 4);
      #1;
      refill(32'(i * 4), 32'hC0DE_0000 + 32'(i), 0);
      check("t6_fill_hit", {31'd0, ihit}, 32'd1);
      check("t6_fill_load", imemload, 32'hC0DE_0000 + 32'(i));
    end
    check("t6_mc16", miss_count, 32'd16);
    for (int i = 0; i < 16; i++) begin
      imemaddr = 32'(i * 4);
      #1;
      check("t6_pass2_hit", {31'd0, ihit}, 32'd1);
      check("t6_pass2_load", imemload, 32'hC0DE_0000 + 32'(i));
      check("t6_pass2_iren", {31'd0, iREN}, 32'd0);
      step();
    end
    check("t6_mc_final", miss_count, 32'd16);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
